// File: rtl/nx_ctrl_pkg.sv
// Shared types for the Nexus cycle controller: run modes and FSM states.
package nx_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_STOP  = 2'd0,
    MODE_FREE  = 2'd1,
    MODE_RUN_N = 2'd2,
    MODE_STEP  = 2'd3
  } nx_mode_e;

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_COMPLETE = 2'd2
  } nx_state_e;

  // RUN_N and STEP both spend a remaining-trigger budget
  function automatic logic is_counted(nx_mode_e m);
    return (m == MODE_RUN_N) || (m == MODE_STEP);
  endfunction

endpackage

// File: rtl/nx_idle_detect.sv
// Combines mesh idle flags; ready once every mesh was busy and then stayed idle for SETTLE_CYCLES.
module nx_idle_detect #(
  parameter int MESHES        = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [MESHES-1:0] mesh_idle_i,
  input  logic              consume_i,
  output logic              ready_o
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  logic          all_idle;
  logic          seen_busy_q, seen_busy_d;
  logic [SW-1:0] settle_q, settle_d;

  assign all_idle = &mesh_idle_i;
  assign ready_o  = seen_busy_q && (settle_q == SW'(SETTLE_CYCLES)) && all_idle;

  always_comb begin
    seen_busy_d = seen_busy_q;
    settle_d    = settle_q;
    if (consume_i) begin
      // a trigger re-arms detection: the mesh must go busy again
      seen_busy_d = 1'b0;
      settle_d    = '0;
    end else if (!all_idle) begin
      seen_busy_d = 1'b1;
      settle_d    = '0;
    end else if (seen_busy_q && (settle_q != SW'(SETTLE_CYCLES))) begin
      settle_d = settle_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seen_busy_q <= 1'b0;
      settle_q    <= '0;
    end else begin
      seen_busy_q <= seen_busy_d;
      settle_q    <= settle_d;
    end
  end

endmodule

// File: rtl/nx_cycle_ctrl.sv
// Nexus trigger/cycle controller: run modes, trigger issue, cycle counter, token seed.
// Optional watchdog enabled by defining NX_CYCLE_CTRL_TIMEOUT_EN.
module nx_cycle_ctrl
  import nx_ctrl_pkg::*;
#(
  parameter int MESHES         = 1,
  parameter int COLUMNS        = 3,
  parameter int COUNTER_WIDTH  = 32,
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               mode_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     clear_i,
  input  logic [COUNTER_WIDTH-1:0] limit_i,
  input  logic [MESHES-1:0]        mesh_idle_i,
  input  logic [COLUMNS-1:0]       token_release_i,
  output logic [COLUMNS-1:0]       token_grant_o,
  output logic                     trigger_o,
  output logic [COUNTER_WIDTH-1:0] counter_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     timeout_o
);

  if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("nx_cycle_ctrl: SETTLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  nx_state_e                state_q;
  nx_mode_e                 mode_q;
  nx_mode_e                 req_mode;
  logic [COUNTER_WIDTH-1:0] remaining_q;
  logic [COUNTER_WIDTH-1:0] counter_q;
  logic                     trigger_q;
  logic                     first_cycle_q;
  logic                     ready;
  logic                     fire;
  logic                     start_ok;
  logic                     wd_hit;

  assign req_mode = nx_mode_e'(mode_i);
  assign start_ok = (state_q == ST_STOPPED) && start_i && !stop_i && (req_mode != MODE_STOP);
  assign fire     = (state_q == ST_RUNNING) && ready && !stop_i &&
                    (!is_counted(mode_q) || (remaining_q != '0));

  nx_idle_detect #(
    .MESHES        (MESHES),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_idle (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mesh_idle_i (mesh_idle_i),
    .consume_i   (fire),
    .ready_o     (ready)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_STOPPED;
      mode_q        <= MODE_STOP;
      remaining_q   <= '0;
      counter_q     <= '0;
      trigger_q     <= 1'b0;
      first_cycle_q <= 1'b1;
    end else begin
      first_cycle_q <= 1'b0;
      trigger_q     <= fire;
      unique case (state_q)
        ST_STOPPED: begin
          // clear lands before a coincident start so the new run counts from zero
          if (clear_i) counter_q <= '0;
          if (start_ok) begin
            mode_q <= req_mode;
            unique case (req_mode)
              MODE_RUN_N: begin
                remaining_q <= limit_i;
                state_q     <= (limit_i == '0) ? ST_COMPLETE : ST_RUNNING;
              end
              MODE_STEP: begin
                remaining_q <= COUNTER_WIDTH'(1);
                state_q     <= ST_RUNNING;
              end
              default: state_q <= ST_RUNNING;
            endcase
          end
        end
        ST_RUNNING: begin
          if (stop_i) begin
            state_q <= ST_STOPPED;
          end else if (fire) begin
            counter_q <= counter_q + 1'b1;
            if (is_counted(mode_q)) begin
              remaining_q <= remaining_q - 1'b1;
              if (remaining_q == COUNTER_WIDTH'(1)) state_q <= ST_COMPLETE;
            end
          end else if (wd_hit) begin
            state_q <= ST_STOPPED;
          end
        end
        ST_COMPLETE: begin
          if (clear_i) counter_q <= '0;
          state_q <= ST_STOPPED;
        end
        default: state_q <= ST_STOPPED;
      endcase
    end
  end

`ifdef NX_CYCLE_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;
  logic            timeout_q;

  // the TIMEOUT_CYCLES-th consecutive trigger-less running cycle aborts the run
  assign wd_hit = (state_q == ST_RUNNING) && !stop_i && !fire &&
                  (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (start_ok || fire)
        wd_q <= '0;
      else if ((state_q == ST_RUNNING) && !stop_i)
        wd_q <= wd_q + 1'b1;
      if (wd_hit)
        timeout_q <= 1'b1;
      else if (clear_i)
        timeout_q <= 1'b0;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign wd_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign token_grant_o = first_cycle_q ? {COLUMNS{1'b1}} : token_release_i;
  assign trigger_o     = trigger_q;
  assign counter_o     = counter_q;
  assign busy_o        = (state_q == ST_RUNNING);
  assign done_o        = (state_q == ST_COMPLETE);

endmodule

// File: tb/tb_nx_cycle_ctrl.sv
// Self-checking bench for nx_cycle_ctrl against a cycle-level behavioural model.
module tb_nx_cycle_ctrl;

  localparam int MESHES = 2;
  localparam int COLS   = 3;
  localparam int CW     = 4;
  localparam int SETTLE = 2;
  localparam int TMO    = 8;

  localparam int S_STOP = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [1:0]        mode_i = '0;
  logic              start_i = 1'b0, stop_i = 1'b0, clear_i = 1'b0;
  logic [CW-1:0]     limit_i = '0;
  logic [MESHES-1:0] mesh_idle_i = '1;
  logic [COLS-1:0]   token_release_i = 3'b101;
  logic [COLS-1:0]   token_grant_o;
  logic              trigger_o, busy_o, done_o, timeout_o;
  logic [CW-1:0]     counter_o;

  nx_cycle_ctrl #(
    .MESHES(MESHES), .COLUMNS(COLS), .COUNTER_WIDTH(CW),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i), .start_i(start_i),
    .stop_i(stop_i), .clear_i(clear_i), .limit_i(limit_i),
    .mesh_idle_i(mesh_idle_i), .token_release_i(token_release_i),
    .token_grant_o(token_grant_o), .trigger_o(trigger_o), .counter_o(counter_o),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- behavioural model ----------------
  int m_st, m_left, m_cnt, m_run, m_wd;
  bit m_first, m_trig, m_timeout, m_counted, m_seen;

  task automatic model_reset();
    m_st = S_STOP; m_left = 0; m_cnt = 0; m_run = 0; m_wd = 0;
    m_first = 1; m_trig = 0; m_timeout = 0; m_counted = 0; m_seen = 0;
  endtask

  // one clock of the spec rules, using the inputs currently applied
  task automatic model_step();
    bit idle, rdy, fire;
    idle = &mesh_idle_i;
    rdy  = m_seen && (m_run >= SETTLE) && idle;
    fire = (m_st == S_RUN) && rdy && !stop_i && (!m_counted || m_left > 0);
    m_first = 0;
    m_trig  = fire;
    if (clear_i) m_timeout = 0;
    case (m_st)
      S_STOP: begin
        if (clear_i) m_cnt = 0;
        if (start_i && !stop_i && mode_i != 2'd0) begin
          m_wd = 0;
          if (mode_i == 2'd1) begin m_counted = 0; m_st = S_RUN; end
          else if (mode_i == 2'd2) begin
            m_counted = 1; m_left = int'(limit_i);
            m_st = (m_left == 0) ? S_DONE : S_RUN;
          end else begin m_counted = 1; m_left = 1; m_st = S_RUN; end
        end
      end
      S_RUN: begin
        if (stop_i) m_st = S_STOP;
        else if (fire) begin
          m_cnt = (m_cnt + 1) % (1 << CW);
          m_wd  = 0;
          if (m_counted) begin
            m_left--;
            if (m_left == 0) m_st = S_DONE;
          end
        end else begin
`ifdef NX_CYCLE_CTRL_TIMEOUT_EN
          m_wd++;
          if (m_wd >= TMO) begin m_timeout = 1; m_st = S_STOP; end
`endif
        end
      end
      default: begin
        if (clear_i) m_cnt = 0;
        m_st = S_STOP;
      end
    endcase
    if (fire) begin m_seen = 0; m_run = 0; end
    else if (!idle) begin m_seen = 1; m_run = 0; end
    else if (m_seen) m_run++;
  endtask

  function automatic logic [10:0] exp_vec();
    logic [COLS-1:0] g;
    logic [CW-1:0]   c;
    g = m_first ? 3'b111 : token_release_i;
    c = CW'(m_cnt);
    return {m_trig, (m_st == S_DONE), (m_st == S_RUN), m_timeout, c, g};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {trigger_o, done_o, busy_o, timeout_o, counter_o, token_grant_o};
  endfunction

  task automatic tick();
    @(negedge clk_i);
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet_inputs();
    start_i = 0; stop_i = 0; clear_i = 0; mode_i = 2'd0; limit_i = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i = 1; quiet_inputs(); mesh_idle_i = '1; token_release_i = 3'b101;
    repeat (2) @(posedge clk_i);
    #1; model_reset(); rst_i = 0;
    #1;
    n_tests++;
    if ({trigger_o, done_o, busy_o, timeout_o, counter_o} !== 8'h00 || token_grant_o !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_state: got %b want trig/done/busy/tmo/cnt=0 grant=111", obs_vec());
    end
    tick();
    n_tests++;
    if (token_grant_o !== 3'b101) begin
      n_fail++; $display("FAIL grant_after_first: got %b want 101", token_grant_o);
    end
    token_release_i = 3'b010; #1;
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL grant_follow: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_free();
    int trigs = 0;
    mode_i = 2'd1; start_i = 1; clear_i = 1; tick(); quiet_inputs();
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 6; c++) begin
        mesh_idle_i = (c < 2) ? 2'b00 : 2'b11;
        tick();
        if (trigger_o) trigs++;
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL free k%0d c%0d: got %b want %b", k, c, obs_vec(), exp_vec());
        end
      end
    end
    repeat (4) tick();
    if (trigger_o) trigs++;
    stop_i = 1; tick(); quiet_inputs();
    n_tests++;
    if (trigs != 5 || counter_o !== 4'd5 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL free_total: trigs %0d cnt %0d busy %b want 5 5 0", trigs, counter_o, busy_o);
    end
  endtask

  task automatic test_run_n();
    int trigs = 0;
    logic [CW-1:0] c0;
    c0 = counter_o;
    mode_i = 2'd2; limit_i = 4'd3; start_i = 1; tick(); quiet_inputs();
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 4; c++) begin
        mesh_idle_i = (c == 0) ? 2'b10 : 2'b11;
        tick();
        if (trigger_o) trigs++;
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL run_n k%0d c%0d: got %b want %b", k, c, obs_vec(), exp_vec());
        end
      end
    end
    n_tests++;
    if (trigs != 3 || counter_o !== c0 + 4'd3 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL run_n_total: trigs %0d cnt %0d want 3 %0d", trigs, counter_o, c0 + 4'd3);
    end
    mesh_idle_i = 2'b11;
    mode_i = 2'd2; limit_i = 4'd0; start_i = 1; tick(); quiet_inputs();
    n_tests++;
    if (done_o !== 1'b1 || trigger_o !== 1'b0 || counter_o !== c0 + 4'd3) begin
      n_fail++; $display("FAIL run_n_zero: done %b trig %b cnt %0d want 1 0 %0d", done_o, trigger_o, counter_o, c0 + 4'd3);
    end
    tick();
    n_tests++;
    if (obs_vec() !== exp_vec() || done_o !== 1'b0) begin
      n_fail++; $display("FAIL run_n_zero_after: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_step();
    logic [MESHES-1:0] pat [8] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    int trigs = 0;
    logic [CW-1:0] c0;
    c0 = counter_o;
    for (int s = 0; s < 2; s++) begin
      mode_i = 2'd3; start_i = 1; tick(); quiet_inputs();
      for (int c = 0; c < 8; c++) begin
        mesh_idle_i = pat[c];
        tick();
        if (trigger_o) trigs++;
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL step s%0d c%0d: got %b want %b", s, c, obs_vec(), exp_vec());
        end
      end
    end
    n_tests++;
    if (trigs != 2 || counter_o !== c0 + 4'd2) begin
      n_fail++; $display("FAIL step_total: trigs %0d cnt %0d want 2 %0d", trigs, counter_o, c0 + 4'd2);
    end
  endtask

  task automatic test_stop_clear();
    mesh_idle_i = 2'b11;
    mode_i = 2'd1; start_i = 1; tick(); quiet_inputs();
    mesh_idle_i = 2'b00; tick();
    mesh_idle_i = 2'b11; tick(); tick();
    stop_i = 1; tick(); stop_i = 0;
    n_tests++;
    if (trigger_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL stop_on_ready: got %b want %b", obs_vec(), exp_vec());
    end
    // mesh is still settled: a fresh start fires on its first running cycle
    mode_i = 2'd1; start_i = 1; tick(); quiet_inputs(); tick();
    n_tests++;
    if (trigger_o !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL restart_settled: got %b want %b", obs_vec(), exp_vec());
    end
    clear_i = 1; tick(); clear_i = 0;
    n_tests++;
    if (counter_o === 4'd0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL clear_running: got %b want %b", obs_vec(), exp_vec());
    end
    stop_i = 1; tick(); stop_i = 0;
    clear_i = 1; tick(); clear_i = 0;
    n_tests++;
    if (counter_o !== 4'd0) begin
      n_fail++; $display("FAIL clear_stopped: got %0d want 0", counter_o);
    end
  endtask

  task automatic test_wrap();
    int trigs = 0;
    clear_i = 1; tick(); quiet_inputs();
    mode_i = 2'd1; start_i = 1; tick(); quiet_inputs();
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < 4; c++) begin
        mesh_idle_i = (c == 0) ? 2'b00 : 2'b11;
        tick();
        if (trigger_o) trigs++;
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL wrap k%0d c%0d: got %b want %b", k, c, obs_vec(), exp_vec());
        end
      end
    end
    n_tests++;
    if (trigs != 16 || counter_o !== 4'd0) begin
      n_fail++; $display("FAIL wrap_total: trigs %0d cnt %0d want 16 0", trigs, counter_o);
    end
    stop_i = 1; tick(); quiet_inputs();
  endtask

  task automatic test_watchdog();
    mesh_idle_i = 2'b00;
    mode_i = 2'd1; start_i = 1; tick(); quiet_inputs();
    for (int c = 0; c < 12; c++) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL watchdog c%0d: got %b want %b", c, obs_vec(), exp_vec());
      end
    end
`ifdef NX_CYCLE_CTRL_TIMEOUT_EN
    n_tests++;
    if (timeout_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL watchdog_fire: tmo %b busy %b want 1 0", timeout_o, busy_o);
    end
`else
    n_tests++;
    if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL watchdog_off: tmo %b busy %b want 0 1", timeout_o, busy_o);
    end
`endif
    stop_i = 1; clear_i = 1; tick(); quiet_inputs(); tick();
    n_tests++;
    if (timeout_o !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL watchdog_clear: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      mesh_idle_i     = ($urandom_range(0, 9) < 7) ? 2'b11 : MESHES'($urandom);
      start_i         = ($urandom_range(0, 9) == 0);
      stop_i          = ($urandom_range(0, 29) == 0);
      clear_i         = ($urandom_range(0, 19) == 0);
      mode_i          = 2'($urandom);
      limit_i         = CW'($urandom_range(0, 4));
      token_release_i = COLS'($urandom);
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random c%0d: got %b want %b", c, obs_vec(), exp_vec());
      end
    end
    quiet_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_free();
    test_run_n();
    test_step();
    test_stop_clear();
    test_wrap();
    test_watchdog();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nx_cycle_ctrl.md
Name: nx_cycle_ctrl

Overview:
Parametrised successor to the top-level trigger/cycle logic of the Nexus accelerator.
- Watches idle flags from one or more meshes.
- Issues single-cycle simulation triggers once every mesh has been busy and then settled idle.
- Keeps the simulated-cycle counter and drives the token-grant seed.
- Adds run modes (free-run, run-N-cycles, single-step), start/stop control, completion pulse and a configurable settle window.
- Sits between the host control registers and the nx_mesh instances.

Parameters:
MESHES, 1, number of mesh instances whose idle flags are combined.
COLUMNS, 3, width of token grant/release vectors.
COUNTER_WIDTH, 32, width of cycle counter and run-length limit.
SETTLE_CYCLES, 1, consecutive all-idle cycles required before a trigger (>=1).
TIMEOUT_CYCLES, 65535, watchdog limit; used only with the optional feature.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
mode_i  in  2  0=STOP, 1=FREE, 2=RUN_N, 3=STEP; sampled only on accepted start_i
start_i  in  1  start pulse
stop_i  in  1  stop request
clear_i  in  1  zero the counter; honoured only when not running
limit_i  in  COUNTER_WIDTH  cycle count for RUN_N; sampled with start_i
mesh_idle_i  in  MESHES  per-mesh idle flags
token_release_i  in  COLUMNS  token release from mesh
token_grant_o  out  COLUMNS  token grant to mesh
trigger_o  out  1  registered single-cycle trigger broadcast to all meshes
counter_o  out  COUNTER_WIDTH  triggers issued since clear/reset
busy_o  out  1  high in RUNNING
done_o  out  1  one-cycle pulse on RUN_N/STEP completion
timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset values: trigger_o=0, counter_o=0, busy_o=0, done_o=0, timeout_o=0. Internal first_cycle=1, seen_busy=0, settle=0, remaining=0, state=STOPPED.
- Token grant:
  - token_grant_o = all-ones while first_cycle=1, otherwise token_release_i (combinational).
  - first_cycle clears on the first clock after reset.
- Idle detection:
  - all_idle = &mesh_idle_i.
  - seen_busy sets when !all_idle.
  - settle increments while all_idle && seen_busy, saturating at SETTLE_CYCLES; it resets to 0 on any !all_idle.
  - ready = seen_busy && settle==SETTLE_CYCLES && all_idle.
- Trigger:
  - Fires in RUNNING && ready && !stop_i, with remaining!=0 when in counted modes.
  - On trigger: trigger_o=1 next cycle, counter +1 (wraps silently), seen_busy=0, settle=0.
  - Min spacing between triggers = 1 busy cycle + SETTLE_CYCLES.
- FSM STOPPED:
  - start_i with mode FREE: go to RUNNING.
  - start_i with mode RUN_N: remaining=limit_i, go to RUNNING. If limit_i==0, go to COMPLETE instead, with no trigger.
  - start_i with mode STEP: remaining=1, go to RUNNING.
  - start_i with mode STOP: ignored.
  - clear_i zeroes counter. clear_i and start_i together: clear applies, then run starts.
- FSM RUNNING:
  - stop_i: go to STOPPED same edge; trigger suppressed; no done_o. stop_i beats start_i.
  - Counted modes: remaining decrements per trigger. At the trigger that makes it 0, go to COMPLETE.
  - start_i and clear_i ignored.
- FSM COMPLETE: done_o=1 for this single cycle, coincident with the final trigger_o. Next state is STOPPED unconditionally.
- seen_busy/settle keep tracking in all states, so a later start can trigger immediately if the mesh is already settled.

Optional Feature:
NX_CYCLE_CTRL_TIMEOUT_EN
- Defined:
  - A watchdog counter counts RUNNING cycles since the last trigger or start.
  - On reaching TIMEOUT_CYCLES it sets timeout_o (sticky) and forces STOPPED, with no done_o.
  - timeout_o clears on clear_i or reset.
- Undefined: no watchdog logic; timeout_o tied 0.

Decomposition:
- Package nx_ctrl_pkg (included via nx_common.svh) holds:
  - mode enum: STOP/FREE/RUN_N/STEP;
  - state enum: STOPPED/RUNNING/COMPLETE.
- Sub-module nx_idle_detect (MESHES, SETTLE_CYCLES):
  - AND-reduction, seen_busy flag and settle counter;
  - output ready; input consume, pulsed with trigger.

Test Plan:
- Reset, MESHES=1: token_grant_o=all-ones for exactly 1 cycle, then equals token_release_i=3'b101. All outputs 0.
- FREE, SETTLE_CYCLES=1, mesh busy 2 cycles / idle loop ×5: exactly 5 trigger_o pulses; counter_o=5; no trigger without an intervening busy cycle.
- RUN_N limit_i=3 with mesh always cycling: 3 triggers; done_o coincident with the 3rd trigger; busy_o falls next cycle; counter_o=3. Repeat with limit_i=0: done_o only, counter unchanged.
- STEP ×2 starts; MESHES=2 with idle flags deasserting at different times: trigger only after both are idle for SETTLE_CYCLES=3; counter_o=2.
- stop_i asserted in the same cycle ready rises: no trigger, busy_o=0, done_o=0. clear_i while RUNNING is ignored; clear_i while STOPPED gives counter_o=0.
- COUNTER_WIDTH=4, counter preloaded to 15 via 15 triggers: next trigger wraps counter_o to 0. With NX_CYCLE_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=8 and mesh stuck busy: timeout_o set at cycle 8, state STOPPED.
